// File: rtl/prim_recursion_bw16_pkg.sv
// Shared definitions for the primitive-recursion sequencer: state encoding and default sizes.
package prim_recursion_bw16_pkg;

  localparam int unsigned DEF_BW      = 16;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Watchdog width able to hold TIMEOUT; never narrower than one bit.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/prim_recursion_bw16_op_step_handshake.sv
// Master side of the REQ/WAIT step handshake: STEP_ST generation, ack/ready detection.
// Optional watchdog enabled by the PRIM_RECURSION_TIMEOUT_EN macro.
module prim_recursion_bw16_op_step_handshake
  import prim_recursion_bw16_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic   CLK,
  input  logic   RST,
  input  state_t state,
  input  logic   launch,
  input  logic   step_rd,
  output logic   step_st,
  output logic   ack_c,
  output logic   ready_c,
  output logic   timeout_c
);

  // The step drops its ready to acknowledge, then raises it when the result is valid.
  assign ack_c   = (state == S_REQ) && !step_rd;
  assign ready_c = (state == S_WAIT) && step_rd;

  always_ff @(posedge CLK) begin
    if (RST) begin
      step_st <= 1'b0;
    end else if (launch) begin
      step_st <= 1'b1;
    end else if ((state == S_REQ) && (!step_rd || timeout_c)) begin
      step_st <= 1'b0;
    end
  end

`ifdef PRIM_RECURSION_TIMEOUT_EN
  localparam int unsigned WDW = wd_width(TIMEOUT);

  logic [WDW-1:0] wd;
  logic           in_hs_c;

  assign in_hs_c   = (state == S_REQ) || (state == S_WAIT);
  assign timeout_c = in_hs_c && (wd == WDW'(TIMEOUT - 1));

  // Restart the count on entry to REQ (launch) and on entry to WAIT (ack).
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd <= '0;
    end else if (launch || ack_c) begin
      wd <= '0;
    end else if (in_hs_c) begin
      wd <= wd + WDW'(1);
    end
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

endmodule

// File: rtl/prim_recursion_bw16.sv
// Primitive-recursion sequencer: R(0,y)=BASE, R(k+1,y)=STEP(R(k,y),k,y), run IN0 times.
// PRIM_RECURSION_TIMEOUT_EN adds a step watchdog that reports through ERR.
module prim_recursion_bw16
  import prim_recursion_bw16_pkg::*;
#(
  parameter int unsigned BW      = DEF_BW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST,
  output logic          RD,
  output logic [BW-1:0] RES,
  output logic          ERR,
  input  logic [BW-1:0] IN0,
  input  logic [BW-1:0] IN1,
  input  logic [BW-1:0] BASE,
  output logic          STEP_ST,
  input  logic          STEP_RD,
  input  logic [BW-1:0] STEP_RES,
  output logic [BW-1:0] STEP_ACC,
  output logic [BW-1:0] STEP_CNT,
  output logic [BW-1:0] STEP_PAR
);

  state_t        state;
  logic          st_old;
  logic [BW-1:0] n;
  logic [BW-1:0] y;
  logic [BW-1:0] acc;
  logic [BW-1:0] k;

  logic start_c;
  logic launch_c;
  logic ack_c;
  logic ready_c;
  logic timeout_c;

  assign start_c  = ST && !st_old;
  assign launch_c = (state == S_CHECK) && (k != n);

  prim_recursion_bw16_op_step_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_hs (
    .CLK       (CLK),
    .RST       (RST),
    .state     (state),
    .launch    (launch_c),
    .step_rd   (STEP_RD),
    .step_st   (STEP_ST),
    .ack_c     (ack_c),
    .ready_c   (ready_c),
    .timeout_c (timeout_c)
  );

  // ST history is tracked even in reset so a level held through reset never starts a run.
  always_ff @(posedge CLK) begin
    st_old <= ST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      RD       <= 1'b1;
      RES      <= '0;
`ifdef PRIM_RECURSION_TIMEOUT_EN
      ERR      <= 1'b0;
`endif
      STEP_ACC <= '0;
      STEP_CNT <= '0;
      STEP_PAR <= '0;
      n        <= '0;
      y        <= '0;
      acc      <= '0;
      k        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_c) begin
            n     <= IN0;
            y     <= IN1;
            acc   <= BASE;
            k     <= '0;
            RD    <= 1'b0;
`ifdef PRIM_RECURSION_TIMEOUT_EN
            ERR   <= 1'b0;
`endif
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (k == n) begin
            RES   <= acc;
            state <= S_DONE;
          end else begin
            STEP_ACC <= acc;
            STEP_CNT <= k;
            STEP_PAR <= y;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_c) begin
            state <= S_WAIT;
`ifdef PRIM_RECURSION_TIMEOUT_EN
          end else if (timeout_c) begin
            RES   <= '1;
            ERR   <= 1'b1;
            state <= S_DONE;
`endif
          end
        end
        S_WAIT: begin
          if (ready_c) begin
            acc   <= STEP_RES;
            k     <= k + BW'(1);
            state <= S_CHECK;
`ifdef PRIM_RECURSION_TIMEOUT_EN
          end else if (timeout_c) begin
            RES   <= '1;
            ERR   <= 1'b1;
            state <= S_DONE;
`endif
          end
        end
        S_DONE: begin
          RD    <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef PRIM_RECURSION_TIMEOUT_EN
  logic unused_timeout;

  assign ERR            = 1'b0;
  assign unused_timeout = timeout_c;
`endif

endmodule
